smpl_cqueue: RTL and testbench



---
 rtl/cq_pkg.sv | 14 +
 rtl/cq_dpram.sv | 32 +++
 rtl/smpl_cqueue.sv | 118 +++++++++++
 tb/tb_smpl_cqueue.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cq_pkg.sv
// Shared defaults and state encoding for the stereo sample circular queue.
// Imported by the RAM and by the queue controller.
package cq_pkg;
  localparam int CQ_DEPTH = 1024;
  localparam int CQ_TAPS  = 1021;
  localparam int CQ_WIDTH = 16;
  localparam int CQ_PTR_W = $clog2(CQ_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SEQ,
    GAP
  } cq_state_t;
endpackage

// File: rtl/cq_dpram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The array has no reset; only written entries are ever streamed.
module cq_dpram
  import cq_pkg::*;
#(
  parameter int DEPTH = CQ_DEPTH,
  parameter int DW    = 2 * CQ_WIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/smpl_cqueue.sv
// Producer side of the filter-band bus: ring buffer of stereo samples that
// streams the newest TAPS samples oldest-first, framed by sequencing.
module smpl_cqueue
  import cq_pkg::*;
#(
  parameter int DEPTH = CQ_DEPTH,
  parameter int TAPS  = CQ_TAPS,
  parameter int WIDTH = CQ_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrt_smpl,
  input  logic [WIDTH-1:0] lft_smpl,
  input  logic [WIDTH-1:0] rght_smpl,
  output logic             sequencing,
  output logic [WIDTH-1:0] lft_out,
  output logic [WIDTH-1:0] rght_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TAPS + 1);
  localparam logic [AW-1:0] TAPS_A = AW'(TAPS);
  localparam logic [CW-1:0] TAPS_C = CW'(TAPS);
  localparam logic [CW-1:0] LAST_C = CW'(TAPS - 1);

  cq_state_t         state_q, state_d;
  logic [AW-1:0]     new_ptr_q, new_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     fill_q, fill_d;
  logic [CW-1:0]     seq_cnt_q, seq_cnt_d;
  logic              pend_q, pend_d;
  logic              seq_q;
  logic              rd_en;
  logic [2*WIDTH-1:0] rdata;

  always_comb begin
    new_ptr_d = new_ptr_q;
    fill_d    = fill_q;
    if (wrt_smpl) begin
      new_ptr_d = new_ptr_q + AW'(1);
      if (fill_q != TAPS_C) fill_d = fill_q + CW'(1);
    end
  end

  // A write landing in GAP is folded into the follow-up window directly.
  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    seq_cnt_d = seq_cnt_q;
    pend_d    = pend_q;
    rd_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wrt_smpl && fill_d == TAPS_C) begin
          state_d   = SEQ;
          rd_ptr_d  = new_ptr_d - TAPS_A;
          seq_cnt_d = '0;
        end
      end
      SEQ: begin
        rd_en     = 1'b1;
        rd_ptr_d  = rd_ptr_q + AW'(1);
        seq_cnt_d = seq_cnt_q + CW'(1);
        if (wrt_smpl) pend_d = 1'b1;
        if (seq_cnt_q == LAST_C) state_d = GAP;
      end
      GAP: begin
        if (pend_q || wrt_smpl) begin
          pend_d    = 1'b0;
          state_d   = SEQ;
          rd_ptr_d  = new_ptr_d - TAPS_A;
          seq_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      new_ptr_q <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      seq_cnt_q <= '0;
      pend_q    <= 1'b0;
      seq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      new_ptr_q <= new_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      seq_cnt_q <= seq_cnt_d;
      pend_q    <= pend_d;
      seq_q     <= rd_en;
    end
  end

  cq_dpram #(
    .DEPTH(DEPTH),
    .DW   (2 * WIDTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (wrt_smpl),
    .waddr_i(new_ptr_q),
    .wdata_i({lft_smpl, rght_smpl}),
    .re_i   (rd_en),
    .raddr_i(rd_ptr_q),
    .rdata_o(rdata)
  );

  assign sequencing = seq_q;
  assign lft_out    = seq_q ? rdata[2*WIDTH-1:WIDTH] : '0;
  assign rght_out   = seq_q ? rdata[WIDTH-1:0] : '0;

endmodule

// File: tb/tb_smpl_cqueue.sv
// Bench for smpl_cqueue: sample history model, expected stream is the
// newest TAPS entries of the history at the time each sequence starts.
module tb_smpl_cqueue;
  import cq_pkg::*;

  localparam int TAPS = CQ_TAPS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrt_smpl = 1'b0;
  logic [15:0] lft_smpl = '0;
  logic [15:0] rght_smpl = '0;
  logic        sequencing;
  logic [15:0] lft_out;
  logic [15:0] rght_out;

  always #5 clk = ~clk;

  smpl_cqueue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wrt_smpl  (wrt_smpl),
    .lft_smpl  (lft_smpl),
    .rght_smpl (rght_smpl),
    .sequencing(sequencing),
    .lft_out   (lft_out),
    .rght_out  (rght_out)
  );

  int nchk = 0;
  int nerr = 0;

  logic [15:0] hist_l[$];
  logic [15:0] hist_r[$];

  logic [15:0] done_l[$];
  logic [15:0] done_r[$];
  int seq_len[$];
  int seq_gap[$];
  int n_rise = 0;
  int zero_bad = 0;
  int low_run = 0;
  int cur_len = 0;
  bit in_seq = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_seq  = 1'b0;
      cur_len = 0;
      low_run = 0;
    end else if (sequencing) begin
      if (!in_seq) begin
        in_seq = 1'b1;
        n_rise++;
        seq_gap.push_back(low_run);
        cur_len = 0;
      end
      done_l.push_back(lft_out);
      done_r.push_back(rght_out);
      cur_len++;
    end else begin
      if (in_seq) begin
        in_seq = 1'b0;
        seq_len.push_back(cur_len);
        low_run = 0;
      end
      low_run++;
    end
    if (!sequencing && (lft_out !== 16'd0 || rght_out !== 16'd0))
      zero_bad++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exhausted, need completion");
    $fatal(1);
  end

  task automatic clear_cap();
    done_l.delete();
    done_r.delete();
    seq_len.delete();
    seq_gap.delete();
    n_rise   = 0;
    zero_bad = 0;
  endtask

  task automatic wr(input logic [15:0] l, input logic [15:0] r);
    lft_smpl  = l;
    rght_smpl = r;
    wrt_smpl  = 1'b1;
    @(negedge clk);
    wrt_smpl  = 1'b0;
    hist_l.push_back(l);
    hist_r.push_back(r);
  endtask

  task automatic wr_rand();
    wr(16'($urandom), 16'($urandom));
  endtask

  task automatic wait_idle(input string nm);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 5000) begin
      @(negedge clk);
      n++;
      quiet = sequencing ? 0 : quiet + 1;
    end
    nchk++;
    if (quiet < 4) begin
      nerr++;
      $display("FAIL %s_timeout: still sequencing after %0d cycles, need idle", nm, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    nchk++;
    if (sequencing !== 1'b0 || lft_out !== 16'd0 || rght_out !== 16'd0) begin
      nerr++;
      $display("FAIL reset_out: seq=%b l=%h r=%h, need 0/0/0", sequencing, lft_out, rght_out);
    end
    rst_n = 1'b1;
    clear_cap();
    repeat (5) @(negedge clk);
    nchk++;
    if (n_rise !== 0) begin
      nerr++;
      $display("FAIL reset_idle: %0d sequences after release, need 0", n_rise);
    end
  endtask

  task automatic test_prime();
    int e;
    int bad;
    clear_cap();
    for (int i = 0; i < TAPS - 1; i++) begin
      wr(16'(i), 16'(-i));
      @(negedge clk);
    end
    nchk++;
    if (n_rise !== 0) begin
      nerr++;
      $display("FAIL prime_early: %0d sequences before priming, need 0", n_rise);
    end
    wr(16'(TAPS - 1), 16'(-(TAPS - 1)));
    nchk++;
    if (sequencing !== 1'b0) begin
      nerr++;
      $display("FAIL prime_e0: sequencing=%b right after E0, need 0", sequencing);
    end
    @(negedge clk);
    nchk++;
    if (sequencing !== 1'b1) begin
      nerr++;
      $display("FAIL prime_e1: sequencing=%b after E1, need 1", sequencing);
    end
    wait_idle("prime");
    nchk++;
    if (n_rise !== 1 || seq_len.size() !== 1 || seq_len[0] !== TAPS) begin
      nerr++;
      $display("FAIL prime_len: rises=%0d segs=%0d len=%0d, need 1/1/%0d",
               n_rise, seq_len.size(), seq_len.size() ? seq_len[0] : -1, TAPS);
    end
    e = hist_l.size() - 1;
    bad = 0;
    if (done_l.size() < TAPS) bad = TAPS;
    else
      for (int k = 0; k < TAPS; k++)
        if (done_l[k] !== hist_l[e-TAPS+1+k] || done_r[k] !== hist_r[e-TAPS+1+k]) bad++;
    nchk++;
    if (bad !== 0) begin
      nerr++;
      $display("FAIL prime_window: %0d bad samples, need 0", bad);
    end
    nchk++;
    if (done_l.size() < TAPS || done_l[0] !== 16'd0 || done_l[TAPS-1] !== 16'd1020 ||
        done_r[TAPS-1] !== 16'hFC04) begin
      nerr++;
      $display("FAIL prime_ends: first/last l=%h/%h last r=%h, need 0000/03fc/fc04",
               done_l.size() ? done_l[0] : 16'hx,
               done_l.size() >= TAPS ? done_l[TAPS-1] : 16'hx,
               done_r.size() >= TAPS ? done_r[TAPS-1] : 16'hx);
    end
    nchk++;
    if (zero_bad !== 0) begin
      nerr++;
      $display("FAIL prime_zero: %0d nonzero idle outputs, need 0", zero_bad);
    end
  endtask

  task automatic test_slide();
    int e;
    int bad;
    clear_cap();
    wr(16'd1021, 16'(-1021));
    wait_idle("slide");
    e = hist_l.size() - 1;
    bad = 0;
    if (n_rise !== 1 || done_l.size() !== TAPS) bad = TAPS;
    else
      for (int k = 0; k < TAPS; k++)
        if (done_l[k] !== hist_l[e-TAPS+1+k] || done_r[k] !== hist_r[e-TAPS+1+k]) bad++;
    nchk++;
    if (bad !== 0 || done_l[0] !== 16'd1) begin
      nerr++;
      $display("FAIL slide_window: bad=%0d first=%0d, need 0 and 1", bad,
               done_l.size() ? done_l[0] : 16'hx);
    end
  endtask

  task automatic test_wrap();
    int base;
    int bad;
    int off;
    clear_cap();
    base = hist_l.size();
    for (int i = 1022; i <= 1029; i++) begin
      wr(16'(i), 16'(-i));
      wait_idle("wrap");
    end
    nchk++;
    if (n_rise !== 8 || done_l.size() !== 8 * TAPS) begin
      nerr++;
      $display("FAIL wrap_count: rises=%0d samples=%0d, need 8 and %0d",
               n_rise, done_l.size(), 8 * TAPS);
    end
    bad = 0;
    if (done_l.size() !== 8 * TAPS) bad = 1;
    else
      for (int s = 0; s < 8; s++) begin
        off = s * TAPS;
        for (int k = 0; k < TAPS; k++)
          if (done_l[off+k] !== hist_l[base+s-TAPS+1+k] ||
              done_r[off+k] !== hist_r[base+s-TAPS+1+k]) bad++;
      end
    nchk++;
    if (bad !== 0 || done_l[7*TAPS] !== 16'd9) begin
      nerr++;
      $display("FAIL wrap_window: bad=%0d last first=%0d, need 0 and 9", bad,
               done_l.size() > 7 * TAPS ? done_l[7*TAPS] : 16'hx);
    end
  endtask

  task automatic test_pending(input string nm, input int nw, input int first_dly,
                              input int step);
    int e0;
    int e1;
    int bad;
    clear_cap();
    wr_rand();
    e0 = hist_l.size() - 1;
    repeat (first_dly) @(negedge clk);
    for (int w = 0; w < nw; w++) begin
      if (w > 0) repeat (step) @(negedge clk);
      wr_rand();
    end
    e1 = hist_l.size() - 1;
    wait_idle(nm);
    nchk++;
    if (n_rise !== 2 || seq_gap.size() < 2 || seq_gap[1] !== 1 ||
        done_l.size() !== 2 * TAPS) begin
      nerr++;
      $display("FAIL %s_frame: rises=%0d gap=%0d samples=%0d, need 2/1/%0d", nm, n_rise,
               seq_gap.size() > 1 ? seq_gap[1] : -1, done_l.size(), 2 * TAPS);
    end
    bad = 0;
    if (done_l.size() !== 2 * TAPS) bad = 1;
    else
      for (int k = 0; k < TAPS; k++) begin
        if (done_l[k] !== hist_l[e0-TAPS+1+k] || done_r[k] !== hist_r[e0-TAPS+1+k]) bad++;
        if (done_l[TAPS+k] !== hist_l[e1-TAPS+1+k] ||
            done_r[TAPS+k] !== hist_r[e1-TAPS+1+k]) bad++;
      end
    nchk++;
    if (bad !== 0) begin
      nerr++;
      $display("FAIL %s_window: %0d bad samples, need 0", nm, bad);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    int bad;
    clear_cap();
    wr_rand();
    repeat (500) @(negedge clk);
    nchk++;
    if (sequencing !== 1'b1) begin
      nerr++;
      $display("FAIL rstmid_pre: sequencing=%b at cycle 500, need 1", sequencing);
    end
    rst_n = 1'b0;
    #1;
    nchk++;
    if (sequencing !== 1'b0 || lft_out !== 16'd0 || rght_out !== 16'd0) begin
      nerr++;
      $display("FAIL rstmid_out: seq=%b l=%h r=%h, need 0/0/0", sequencing, lft_out, rght_out);
    end
    hist_l.delete();
    hist_r.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_cap();
    for (int i = 0; i < TAPS - 1; i++) begin
      wr_rand();
      @(negedge clk);
    end
    nchk++;
    if (n_rise !== 0) begin
      nerr++;
      $display("FAIL rstmid_reprime: %0d sequences before re-prime, need 0", n_rise);
    end
    wr_rand();
    wait_idle("rstmid");
    e = hist_l.size() - 1;
    bad = 0;
    if (n_rise !== 1 || done_l.size() !== TAPS) bad = TAPS;
    else
      for (int k = 0; k < TAPS; k++)
        if (done_l[k] !== hist_l[e-TAPS+1+k] || done_r[k] !== hist_r[e-TAPS+1+k]) bad++;
    nchk++;
    if (bad !== 0) begin
      nerr++;
      $display("FAIL rstmid_window: rises=%0d bad=%0d, need 1 and 0", n_rise, bad);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_prime();
    test_slide();
    test_wrap();
    test_pending("pend1", 1, 300, 0);
    test_pending("pend3", 3, 200, 250);
    test_pending("pend_edge", 1, TAPS - 1, 0);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
